// File: rtl/door_motor_ctrl.sv
// Door motor controller: five-state travel FSM with limit switches, travel timeout and fault latch.
// Optional `DOOR_OBSTRUCT_REVERSE_EN: an obstruction while closing reverses the door to OPENING.
module door_motor_ctrl #(
    parameter int TRAVEL_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door_open,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       obstruct,
    input  logic       fault_clr,
    output logic       motor_fwd,
    output logic       motor_rev,
    output logic [2:0] door_state,
    output logic       fault
);

    localparam int TW = $clog2(TRAVEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          timeout;
    logic          both_lim;
    logic          obs_rev;

    assign timeout  = (timer == TW'(TRAVEL_TIMEOUT - 1));
    assign both_lim = lim_open && lim_closed;

`ifdef DOOR_OBSTRUCT_REVERSE_EN
    assign obs_rev = obstruct;
`else
    logic unused_obstruct;
    assign unused_obstruct = obstruct;
    assign obs_rev         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLOSED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        case (state)
            ST_CLOSED: begin
                if (both_lim)       state_nxt = ST_FAULT;
                else if (door_open) state_nxt = ST_OPENING;
            end
            ST_OPENING: begin
                if (both_lim)        state_nxt = ST_FAULT;
                else if (lim_open)   state_nxt = ST_OPEN;
                else if (!door_open) state_nxt = ST_CLOSING;
                else if (timeout)    state_nxt = ST_FAULT;
            end
            ST_OPEN: begin
                // An obstruction that forced a reopen keeps the door parked open until it clears.
                if (both_lim)        state_nxt = ST_FAULT;
                else if (obs_rev)    state_nxt = ST_OPEN;
                else if (!door_open) state_nxt = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (both_lim)        state_nxt = ST_FAULT;
                else if (lim_closed) state_nxt = ST_CLOSED;
                else if (obs_rev)    state_nxt = ST_OPENING;
                else if (door_open)  state_nxt = ST_OPENING;
                else if (timeout)    state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clr) state_nxt = lim_closed ? ST_CLOSED : ST_CLOSING;
            end
            default: state_nxt = ST_CLOSED;
        endcase

        // Any transition, including a reversal, restarts the travel timer.
        if ((state_nxt == state) && ((state == ST_OPENING) || (state == ST_CLOSING)))
            timer_nxt = timer + TW'(1);
    end

    assign door_state = state;
    assign motor_fwd  = (state == ST_OPENING);
    assign motor_rev  = (state == ST_CLOSING);
    assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Scoreboard bench for door_motor_ctrl (TRAVEL_TIMEOUT=8): directed steps queue expected states,
// a monitor compares state and decoded outputs after each rising edge.
module tb_door_motor_ctrl;

    localparam int TT = 8;
    localparam logic [2:0] S_CL = 3'd0, S_OG = 3'd1, S_OP = 3'd2, S_CG = 3'd3, S_F = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       door_open = 1'b0, lim_open = 1'b0, lim_closed = 1'b0;
    logic       obstruct = 1'b0, fault_clr = 1'b0;
    logic       motor_fwd, motor_rev, fault;
    logic [2:0] door_state;

    int checks = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    string      name_q[$];

    door_motor_ctrl #(.TRAVEL_TIMEOUT(TT)) dut (
        .clk        (clk),
        .rst        (rst),
        .door_open  (door_open),
        .lim_open   (lim_open),
        .lim_closed (lim_closed),
        .obstruct   (obstruct),
        .fault_clr  (fault_clr),
        .motor_fwd  (motor_fwd),
        .motor_rev  (motor_rev),
        .door_state (door_state),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Expected {door_state, motor_fwd, motor_rev, fault} for a given state.
    function automatic logic [5:0] expect_out(input logic [2:0] st);
        return {st, st == S_OG, st == S_CG, st == S_F};
    endfunction

    task automatic check_out(input string nm, input logic [2:0] st);
        logic [5:0] act;
        logic [5:0] req;
        act = {door_state, motor_fwd, motor_rev, fault};
        req = expect_out(st);
        checks++;
        if (act !== req || (motor_fwd && motor_rev)) begin
            failures++;
            $display("FAIL %s: got state=%0d fwd=%b rev=%b fault=%b, want state=%0d fwd=%b rev=%b fault=%b",
                     nm, act[5:3], act[2], act[1], act[0], req[5:3], req[2], req[1], req[0]);
        end
    endtask

    task automatic step(input logic d, input logic lo, input logic lc, input logic ob,
                        input logic fc, input logic [2:0] st, input string nm);
        @(negedge clk);
        door_open  = d;
        lim_open   = lo;
        lim_closed = lc;
        obstruct   = ob;
        fault_clr  = fc;
        exp_q.push_back(st);
        name_q.push_back(nm);
    endtask

    // Monitor: one expected entry per rising edge after the step that queued it.
    initial begin
        logic [2:0] e;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check_out(n, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] obs_exp;
        int         wait_cyc;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", S_CL);
        @(negedge clk);
        rst = 1'b0;

        // Open with limit arriving after three OPENING cycles
        step(1, 0, 0, 0, 0, S_OG, "open_start");
        step(1, 0, 0, 0, 0, S_OG, "opening_1");
        step(1, 0, 0, 0, 0, S_OG, "opening_2");
        step(1, 1, 0, 0, 0, S_OP, "open_arrive");
        step(1, 0, 0, 0, 0, S_OP, "open_hold");

        // Close with no limit switch: exactly TT cycles of CLOSING, then FAULT
        step(0, 0, 0, 0, 0, S_CG, "close_start");
        for (int i = 1; i < TT; i++) step(0, 0, 0, 0, 0, S_CG, "closing");
        step(0, 0, 0, 0, 0, S_F, "close_timeout");
        step(1, 1, 0, 1, 0, S_F, "fault_ignore");
        step(0, 0, 1, 0, 1, S_CL, "clr_to_closed");

        // Reversal at timer=4 restarts the timer: full TT cycles of CLOSING follow
        step(1, 0, 0, 0, 0, S_OG, "reopen");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, S_OG, "reopening");
        step(0, 0, 0, 0, 0, S_CG, "reverse");
        for (int i = 1; i < TT; i++) step(0, 0, 0, 0, 0, S_CG, "rev_closing");
        step(0, 0, 0, 0, 0, S_F, "reverse_timeout");
        step(0, 0, 0, 0, 1, S_CG, "clr_to_closing");
        step(0, 0, 1, 0, 0, S_CL, "closed_arrive");

        // Both limits together while OPEN
        step(1, 0, 0, 0, 0, S_OG, "open_again");
        step(1, 1, 0, 0, 0, S_OP, "open_again_arrive");
        step(1, 1, 1, 0, 0, S_F, "both_limits");
        step(0, 0, 1, 0, 1, S_CL, "clr_both");

        // lim_open on the timeout cycle wins over the timeout
        step(1, 0, 0, 0, 0, S_OG, "slow_open");
        for (int i = 1; i < TT; i++) step(1, 0, 0, 0, 0, S_OG, "slow_opening");
        step(1, 1, 0, 0, 0, S_OP, "open_at_timeout");

        // Asynchronous reset mid-CLOSING
        step(0, 0, 0, 0, 0, S_CG, "close_for_rst");
        step(0, 0, 0, 0, 0, S_CG, "closing_for_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_out("async_reset", S_CL);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0, S_OG, "post_rst_open");
        step(1, 1, 0, 0, 0, S_OP, "post_rst_arrive");

        // Obstruction while closing
`ifdef DOOR_OBSTRUCT_REVERSE_EN
        obs_exp = S_OG;
`else
        obs_exp = S_CG;
`endif
        step(0, 0, 0, 0, 0, S_CG, "close_for_obs");
        step(0, 0, 0, 1, 0, obs_exp, "obstruct");

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
